// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write handshake bundle feeding the uart_tx_fifo buffer
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, back-to-back LSB-first frames
// Parity state and logic are built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_fifo_if.slave               s,
  input  logic                        parity_on,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;

  state_t               state, state_nxt;
  logic [BW-1:0]        baud_cnt, baud_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 tx_nxt, busy_nxt, baud_end;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_en, par_bit;
`else
  logic unused_parity_on;
  assign unused_parity_on = parity_on;
`endif

  assign s.s_ready = (fifo_count < FULL);
  assign push      = s.s_valid && s.s_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
`ifdef UART_TX_PARITY_EN
      // Parity mode and bit are fixed for the whole frame at pop time.
      if (pop) begin
        par_en  <= parity_on;
        par_bit <= (^head) ^ ODD;
      end
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    tx_nxt    = tx;
    busy_nxt  = tx_busy;
    pop       = 1'b0;
    baud_end  = (baud_cnt == BAUD_LAST);
    case (state)
      IDLE: begin
        baud_nxt = '0;
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: if (baud_end) begin
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = DATA;
        tx_nxt    = shift[0];
      end
      DATA: if (baud_end) begin
        baud_nxt = '0;
        if (bit_cnt == DATA_LAST) begin
          bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
          if (par_en) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
`else
          state_nxt = STOP;
          tx_nxt    = 1'b1;
`endif
        end else begin
          bit_nxt   = bit_cnt + 1'b1;
          shift_nxt = shift >> 1;
          tx_nxt    = shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_end) begin
        baud_nxt  = '0;
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end
`endif
      STOP: if (baud_end) begin
        baud_nxt = '0;
        if (bit_cnt == STOP_LAST) begin
          bit_nxt = '0;
          // Chain straight into the next start bit so queued frames have no gap.
          if (fifo_count != '0) begin
            pop       = 1'b1;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (pop) shift_nxt = head;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo (8N1 and 7-bit/2-stop units)
module tb_uart_tx_fifo;
  localparam int CF = 1600;
  localparam int BR = 100;
  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if1 ();
  logic       pon0 = 1'b0, pon1 = 1'b0;
  logic       tx0, tx1, busy0, busy1;
  logic [2:0] cnt0, cnt1;

  uart_tx_fifo #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s(if0), .parity_on(pon0),
    .tx(tx0), .tx_busy(busy0), .fifo_count(cnt0));

  uart_tx_fifo #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .STOP_BITS(2),
                 .FIFO_DEPTH(4), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s(if1), .parity_on(pon1),
    .tx(tx1), .tx_busy(busy1), .fifo_count(cnt1));

  int total = 0;
  int bad = 0;
  int exp0[$], exp1[$], run0[$], run1[$];

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int n_data(input int u);  return (u == 0) ? 8 : 7; endfunction
  function automatic int n_stop(input int u);  return (u == 0) ? 1 : 2; endfunction
  function automatic int odd_of(input int u);  return (u == 0) ? 0 : 1; endfunction
  function automatic logic get_tx(input int u);   return (u == 0) ? tx0 : tx1; endfunction
  function automatic logic get_busy(input int u); return (u == 0) ? busy0 : busy1; endfunction
  function automatic logic get_rdy(input int u);  return (u == 0) ? if0.s_ready : if1.s_ready; endfunction
  function automatic int get_cnt(input int u);    return (u == 0) ? int'(cnt0) : int'(cnt1); endfunction
  function automatic int exp_size(input int u);   return (u == 0) ? exp0.size() : exp1.size(); endfunction
  function automatic int run_size(input int u);   return (u == 0) ? run0.size() : run1.size(); endfunction

  // Model: a frame is start + data + optional parity + stop bits, BD cycles each.
  function automatic int frame_len(input int u, input bit p);
    return (1 + n_data(u) + int'(p) + n_stop(u)) * BD;
  endfunction

  function automatic bit eff_pon(input int u);
    return PAR_BUILT && ((u == 0) ? pon0 : pon1);
  endfunction

  task automatic drive(input int u, input logic v, input int d);
    if (u == 0) begin
      if0.s_valid = v;
      if0.s_data  = 8'(d);
    end else begin
      if1.s_valid = v;
      if1.s_data  = 7'(d);
    end
  endtask

  task automatic send(input int u, input int d);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      drive(u, 1'b1, d);
      acc = get_rdy(u);
      @(posedge clk);
      n++;
    end
    if (acc) begin
      if (u == 0) exp0.push_back(d | (int'(eff_pon(0)) << 16));
      else        exp1.push_back(d | (int'(eff_pon(1)) << 16));
    end else begin
      check("send_timeout", 0, 1);
    end
  endtask

  task automatic release_valid(input int u);
    @(negedge clk);
    drive(u, 1'b0, 0);
  endtask

  task automatic wait_run(input int u, input int req, input string nm);
    int n = 0;
    int r;
    while (run_size(u) == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (run_size(u) == 0) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      r = (u == 0) ? run0.pop_front() : run1.pop_front();
      check(nm, r, req);
    end
  endtask

  task automatic drain(input int u);
    int n = 0;
    while ((exp_size(u) != 0 || get_busy(u)) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", int'(exp_size(u) == 0 && !get_busy(u)), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic busy_mon(input int u);
    int c = 0;
    forever begin
      @(negedge clk);
      if (get_busy(u)) c++;
      else if (c > 0) begin
        if (u == 0) run0.push_back(c);
        else        run1.push_back(c);
        c = 0;
      end
    end
  endtask

  // Samples each frame at bit centres and scores it against the queued word.
  task automatic monitor(input int u);
    int e, d, got, nb, pb;
    bit p, abort, frm_ok;
    logic b;
    forever begin
      @(negedge clk);
      if (rst_n && get_tx(u) == 1'b0) begin
        if (exp_size(u) == 0) begin
          check("unexpected_frame", 1, 0);
          e = 0;
        end else begin
          e = (u == 0) ? exp0.pop_front() : exp1.pop_front();
        end
        d = e & 'hFFFF;
        p = e[16];
        nb = 1 + n_data(u) + int'(p) + n_stop(u);
        got = 0; pb = 0; abort = 1'b0; frm_ok = 1'b1;
        for (int j = 0; j < nb && !abort; j++) begin
          for (int k = 0; k < ((j == 0) ? 8 : 16); k++) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
          end
          b = get_tx(u);
          if (!get_busy(u)) frm_ok = 1'b0;
          if (j == 0) begin
            if (b !== 1'b0) frm_ok = 1'b0;
          end else if (j <= n_data(u)) begin
            got = got | (int'(b) << (j - 1));
          end else if (p && j == n_data(u) + 1) begin
            pb = int'(b);
          end else if (b !== 1'b1) begin
            frm_ok = 1'b0;
          end
        end
        for (int k = 0; k < 7 && !abort; k++) begin
          @(negedge clk);
          if (!rst_n) abort = 1'b1;
        end
        if (!abort) begin
          check($sformatf("frame_data_u%0d", u), got, d);
          check($sformatf("frame_shape_u%0d", u), int'(frm_ok), 1);
          if (p) check($sformatf("parity_u%0d", u), pb, ($countones(d) & 1) ^ odd_of(u));
        end
      end
    end
  endtask

  initial begin
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    fork
      monitor(0);
      monitor(1);
      busy_mon(0);
      busy_mon(1);
    join_none

    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_tx", int'(get_tx(u)), 1);
      check("rst_busy", int'(get_busy(u)), 0);
      check("rst_count", get_cnt(u), 0);
      check("rst_ready", int'(get_rdy(u)), 1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 'hA5);
    #1;
    check("lat_count_one", get_cnt(0), 1);
    check("lat_tx_idle", int'(tx0), 1);
    release_valid(0);
    @(posedge clk); #1;
    check("lat_count_zero", get_cnt(0), 0);
    check("lat_tx_start", int'(tx0), 0);
    check("lat_busy", int'(busy0), 1);
    wait_run(0, frame_len(0, 1'b0), "busy_a5");
    drain(0);

    pon0 = 1'b1;
    send(0, 'h07);
    release_valid(0);
    wait_run(0, frame_len(0, PAR_BUILT), "busy_par_even");
    drain(0);
    pon0 = 1'b0;
    send(0, 'h07);
    release_valid(0);
    wait_run(0, frame_len(0, 1'b0), "busy_par_off");
    drain(0);

    for (int i = 1; i <= 6; i++) begin
      send(0, i);
      if (i == 5) begin
        #1;
        check("burst_count_full", get_cnt(0), 4);
        check("burst_ready_low", int'(if0.s_ready), 0);
      end
    end
    release_valid(0);
    wait_run(0, 6 * frame_len(0, 1'b0), "busy_burst");
    drain(0);

    send(0, 'h11);
    send(0, 'h22);
    send(0, 'h33);
    release_valid(0);
    repeat (54) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", int'(tx0), 1);
    check("abort_busy", int'(busy0), 0);
    check("abort_count", get_cnt(0), 0);
    @(negedge clk);
    #1;
    exp0.delete();
    run0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 'h3C);
    release_valid(0);
    wait_run(0, frame_len(0, 1'b0), "busy_after_reset");
    drain(0);

    send(1, 'h41);
    release_valid(1);
    wait_run(1, frame_len(1, 1'b0), "busy_7n2");
    drain(1);
    pon1 = 1'b1;
    send(1, 'h07);
    release_valid(1);
    wait_run(1, frame_len(1, PAR_BUILT), "busy_par_odd");
    drain(1);
    pon1 = 1'b0;

    for (int r = 0; r < 4; r++) begin
      pon0 = 1'($urandom_range(0, 1));
      pon1 = 1'($urandom_range(0, 1));
      for (int u = 0; u < 2; u++) begin
        for (int w = 0; w < int'($urandom_range(1, 5)); w++) begin
          send(u, int'($urandom & ((u == 0) ? 32'hFF : 32'h7F)));
          if ($urandom_range(0, 1) == 1) begin
            release_valid(u);
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        release_valid(u);
      end
      drain(0);
      drain(1);
      run0.delete();
      run1.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end
endmodule
